// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register.
// Holds stage limits, counter defaults and the per-cycle priority encoding.
package pipe_pkg;

    localparam int unsigned PIPE_MAX_STAGES    = 4;
    localparam int unsigned PIPE_DEFAULT_CNT_W = 16;

    localparam logic [1:0] PRI_RST   = 2'd0;
    localparam logic [1:0] PRI_FLUSH = 2'd1;
    localparam logic [1:0] PRI_STALL = 2'd2;
    localparam logic [1:0] PRI_LOAD  = 2'd3;

    function automatic logic [1:0] pipePriority(input logic rst, input logic flush,
                                                input logic stall);
        logic [1:0] pri;
        if (rst) begin
            pri = PRI_RST;
        end else if (flush) begin
            pri = PRI_FLUSH;
        end else if (stall) begin
            pri = PRI_STALL;
        end else begin
            pri = PRI_LOAD;
        end
        return pri;
    endfunction

endpackage

// File: rtl/pipe_reg_level.sv
// One register level of the pipeline stage register.
// Control and valid clear independently of data so a bubble can keep its data bits.
module pipe_reg_level
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clrCtrl,
    input  logic              clrData,
    input  logic              validIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              validOut,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic [DATA_W-1:0] dataOut
);

    always_ff @(posedge clk) begin
        if (rst || clrCtrl) begin
            validOut <= 1'b0;
            ctrlOut  <= '0;
        end else if (en) begin
            validOut <= validIn;
            // Control of an invalid entry is stored as zero so it can never leak downstream.
            ctrlOut  <= validIn ? ctrlIn : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clrData) begin
            dataOut <= '0;
        end else if (en) begin
            dataOut <= dataIn;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/flush handling
// and saturating stall/bubble event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned DATA_W     = 69,
    parameter int unsigned STAGES     = 1,
    parameter int unsigned FLUSH_DATA = 0,
    parameter int unsigned CNT_W      = PIPE_DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : gBadStages
        $error("pipe_stage_reg: STAGES=%0d outside 1..%0d", STAGES, PIPE_MAX_STAGES);
    end

    logic [1:0] pri;
    assign pri = pipePriority(rst, flush, stall);

    // Index 0 is the stage input; index i+1 is the output of level i.
    logic              lvlValid [STAGES+1];
    logic [CTRL_W-1:0] lvlCtrl  [STAGES+1];
    logic [DATA_W-1:0] lvlData  [STAGES+1];

    assign lvlValid[0] = valid_d;
    assign lvlCtrl[0]  = ctrl_d;
    assign lvlData[0]  = data_d;

    for (genvar i = 0; i < STAGES; i++) begin : gLevel
        logic en;
        logic clrCtrl;
        logic clrData;

        if (i == 0) begin : gHead
            assign en      = (pri == PRI_LOAD);
            assign clrCtrl = (pri == PRI_FLUSH);
            assign clrData = (pri == PRI_FLUSH) && (FLUSH_DATA != 0);
        end else begin : gBody
            // Downstream levels keep advancing during a flush so the bubble moves on.
            assign en      = (pri == PRI_LOAD) || (pri == PRI_FLUSH);
            assign clrCtrl = 1'b0;
            assign clrData = 1'b0;
        end

        pipe_reg_level #(
            .CTRL_W(CTRL_W),
            .DATA_W(DATA_W)
        ) uLevel (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clrCtrl (clrCtrl),
            .clrData (clrData),
            .validIn (lvlValid[i]),
            .ctrlIn  (lvlCtrl[i]),
            .dataIn  (lvlData[i]),
            .validOut(lvlValid[i+1]),
            .ctrlOut (lvlCtrl[i+1]),
            .dataOut (lvlData[i+1])
        );
    end

    assign valid_q = lvlValid[STAGES];
    assign ctrl_q  = lvlValid[STAGES] ? lvlCtrl[STAGES] : '0;
    assign data_q  = lvlData[STAGES];

    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] bubbleCnt;

    always_ff @(posedge clk) begin
        if (pri == PRI_RST) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else if (pri == PRI_FLUSH) begin
            if (bubbleCnt != '1) begin
                bubbleCnt <= bubbleCnt + CNT_W'(1);
            end
        end else if (pri == PRI_STALL) begin
            if (stallCnt != '1) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stallCnt;
    assign bubble_cnt = bubbleCnt;

endmodule
